// File: rtl/serial_multiplier16bit.sv
// Free-running 16x16->32 unsigned shift-and-add multiplier.
// Each 17-cycle frame is one load edge plus 16 iterate edges, and it yields one product.
`timescale 1ns/1ps

module serial_multiplier16bit (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Serial_multin1,
   input  logic [15:0] Serial_multin2,
   output logic [31:0] Serial_multout
);

   localparam logic [4:0] CNT_LOAD = 5'd0;
   localparam logic [4:0] CNT_LAST = 5'd16;

   logic [4:0]  cnt_q,    cnt_d;
   logic [31:0] mcand_q,  mcand_d;
   logic [15:0] mplier_q, mplier_d;
   logic [31:0] acc_q,    acc_d;
   logic [31:0] out_q,    out_d;
   logic [31:0] partial_sum;

   // On the last iterate edge this sum goes straight to the output, so the final add costs no extra cycle.
   assign partial_sum = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

   always_comb begin
      // NOTE: hold every register by default so that no path through this block infers a latch.
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      out_d    = out_q;

      if (cnt_q == CNT_LOAD) begin
         mcand_d  = {16'd0, Serial_multin1};
         mplier_d = Serial_multin2;
         acc_d    = 32'd0;
         cnt_d    = 5'd1;
      end else begin
         acc_d    = partial_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         if (cnt_q == CNT_LAST) begin
            out_d = partial_sum;
            cnt_d = CNT_LOAD;
         end else begin
            cnt_d = cnt_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= CNT_LOAD;
         mcand_q  <= 32'd0;
         mplier_q <= 16'd0;
         acc_q    <= 32'd0;
         out_q    <= 32'd0;
      end else begin
         // NOTE: non-blocking updates make every register see the pre-edge values of the others.
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         out_q    <= out_d;
      end
   end

   assign Serial_multout = out_q;

endmodule

// File: tb/tb_serial_multiplier16bit.sv
// Self-checking bench for serial_multiplier16bit: table vectors, corner sequences, and
// randomized continuous operation checked against a plain a*b reference.
`timescale 1ns/1ps

module tb_serial_multiplier16bit;

   logic        clk;
   logic        rst;
   logic [15:0] in1;
   logic [15:0] in2;
   logic [31:0] prod;

   int n_vec = 0;
   int n_err = 0;

   serial_multiplier16bit dut (
      .clk            (clk),
      .rst            (rst),
      .Serial_multin1 (in1),
      .Serial_multin2 (in2),
      .Serial_multout (prod)
   );

   // First rising edge at 10 ns, period 10 ns.
   initial begin
      clk = 1'b0;
      #10;
      forever begin
         clk = 1'b1;
         #5 clk = 1'b0;
         #5;
      end
   end

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp;
   } vec_t;

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] wa, wb;
      wa = {16'd0, a};
      wb = {16'd0, b};
      return wa * wb;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Call this just after an edge. The pulse is asserted and released between two edges.
   task automatic pulse_reset(input string name);
      rst = 1'b1;
      #1 check({name, "_async"}, prod, 32'd0);
      #2 rst = 1'b0;
   endtask

   // One 17-edge frame. Call it right after reset release or right after a result edge.
   // The output must hold `prev` for 16 edges and then show `exp`.
   // With chg_edge > 0, the inputs change to (ca, cb) just after that edge.
   task automatic run_window(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [31:0] prev, input logic [31:0] exp,
                             input int chg_edge, input logic [15:0] ca, input logic [15:0] cb);
      logic        ok;
      logic [31:0] bad;
      ok  = 1'b1;
      bad = prev;
      in1 = a;
      in2 = b;
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (ok && prod !== prev) begin
            ok  = 1'b0;
            bad = prod;
         end
         if (e == chg_edge) begin
            in1 = ca;
            in2 = cb;
         end
      end
      check({name, "_hold"}, bad, prev);
      tick();
      check(name, prod, exp);
   endtask

   vec_t vecs[7];

   initial begin
      logic [15:0] ra, rb, ca, cb;
      logic [31:0] prev_r, exp_r;
      int          ce;

      vecs[0] = '{"small_3x5",      16'h0003, 16'h0005, 32'd15};
      vecs[1] = '{"zero_a",         16'h0000, 16'hABCD, 32'd0};
      vecs[2] = '{"zero_b",         16'hFFFF, 16'h0000, 32'd0};
      vecs[3] = '{"one_x_one",      16'h0001, 16'h0001, 32'd1};
      vecs[4] = '{"msb_x_two",      16'h8000, 16'h0002, 32'h0001_0000};
      vecs[5] = '{"ffff_x_one",     16'hFFFF, 16'h0001, 32'h0000_FFFF};
      vecs[6] = '{"two_x_ffff",     16'h0002, 16'hFFFF, 32'h0001_FFFE};

      // Maximum operands. Reset is released at 5 ns, so the result edge falls at 170 ns.
      rst = 1'b1;
      in1 = 16'hFFFF;
      in2 = 16'hFFFF;
      #1 check("reset_state", prod, 32'd0);
      #4 rst = 1'b0;
      run_window("max_ffff", 16'hFFFF, 16'hFFFF, 32'd0, 32'hFFFE_0001, 0, 16'h0, 16'h0);
      check("max_result_time", 32'($time), 32'd171);

      // Table vectors. Each one starts from a fresh reset, which also clears the previous result.
      for (int i = 0; i < 7; i++) begin
         pulse_reset({vecs[i].name, "_rst"});
         run_window(vecs[i].name, vecs[i].a, vecs[i].b, 32'd0, vecs[i].exp, 0, 16'h0, 16'h0);
      end

      // The inputs change mid-operation. The first product ignores the change and the second uses it.
      pulse_reset("midchg_rst");
      run_window("midchg_first", 16'h1234, 16'h0010, 32'd0, 32'h0001_2340, 5, 16'hFFFF, 16'hFFFF);
      run_window("midchg_second", 16'hFFFF, 16'hFFFF, 32'h0001_2340, 32'hFFFE_0001,
                 0, 16'h0, 16'h0);

      // Back-to-back results with constant inputs.
      pulse_reset("b2b_rst");
      run_window("b2b_1", 16'h00FF, 16'h0101, 32'd0,         32'h0000_FFFF, 0, 16'h0, 16'h0);
      run_window("b2b_2", 16'h00FF, 16'h0101, 32'h0000_FFFF, 32'h0000_FFFF, 0, 16'h0, 16'h0);
      run_window("b2b_3", 16'h00FF, 16'h0101, 32'h0000_FFFF, 32'h0000_FFFF, 0, 16'h0, 16'h0);

      // Reset at edge 8 of 0xFFFF x 0x0002. The output is nonzero beforehand, so the clear is visible.
      in1 = 16'hFFFF;
      in2 = 16'h0002;
      for (int e = 1; e <= 8; e++) tick();
      check("midrst_before", prod, 32'h0000_FFFF);
      pulse_reset("midrst");
      run_window("midrst_full", 16'hFFFF, 16'h0002, 32'd0, 32'h0001_FFFE, 0, 16'h0, 16'h0);

      // Random continuous operation, with random mid-frame input changes that must be ignored.
      pulse_reset("rand_rst");
      prev_r = 32'd0;
      for (int k = 0; k < 24; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (k == 0) ra = 16'hFFFF;
         ce = (k % 3 == 0) ? 0 : int'($urandom_range(1, 16));
         ca = 16'($urandom);
         cb = 16'($urandom);
         exp_r = ref_mul(ra, rb);
         // Without a change the next frame reloads ra/rb. Keep the chain consistent either way.
         run_window($sformatf("rand_%0d", k), ra, rb, prev_r, exp_r, ce, ca, cb);
         prev_r = exp_r;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_multiplier16bit.md
SERIAL_MULTIPLIER16BIT -- requirements
Module: serial_multiplier16bit

Interface
Parameters: none; all widths are fixed.
REQ-001 The block SHALL have port `clk`: input, 1 bit, single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-003 The block SHALL have port `Serial_multin1`: input, 16 bits, unsigned multiplicand.
REQ-004 The block SHALL have port `Serial_multin2`: input, 16 bits, unsigned multiplier.
REQ-005 The block SHALL have port `Serial_multout`: output, 32 bits, registered unsigned product.

Function
REQ-006 The block SHALL compute `Serial_multin1 * Serial_multin2` as an unsigned 16x16->32 product using a shift-and-add algorithm that consumes one multiplier bit per clock.
REQ-007 The block SHALL contain a 5-bit cycle counter `cnt` with range 0..16; `cnt`=0 is the LOAD phase and `cnt`=1..16 are the ITERATE phase.
REQ-008 At the LOAD rising edge, the block SHALL:
- capture both operands into internal registers (multiplicand zero-extended to 32 bits);
- clear the 32-bit accumulator;
- set `cnt` to 1.
REQ-009 On each ITERATE edge, the block SHALL:
- add the shifted multiplicand to the accumulator when the current multiplier LSB is 1;
- shift the multiplicand left by 1 and the multiplier right by 1;
- increment `cnt`.
REQ-010 On the ITERATE edge where `cnt`=16, the block SHALL write the final sum (accumulator plus the last partial product) to `Serial_multout` and return `cnt` to 0 (LOAD).
REQ-011 Latency SHALL be exactly 17 rising edges from the LOAD edge to the `Serial_multout` update, counting the LOAD edge as edge 1 and the update on edge 17.
REQ-012 The block SHALL run continuously with no start or done handshake: after each result it immediately reloads the current inputs and recomputes, giving one new result every 17 cycles.
REQ-013 `Serial_multout` SHALL change only on the result edge and SHALL hold its value for the 16 cycles in between.
REQ-014 Input changes during ITERATE SHALL be ignored; only values present at a LOAD edge are used.
REQ-015 Arithmetic SHALL be unsigned and exact with no overflow, since a 32-bit result is sufficient (max 0xFFFF*0xFFFF = 0xFFFE0001).
REQ-016 A zero operand SHALL produce 0 after the full 17 cycles; the block SHALL NOT terminate early.

Reset
REQ-017 While `rst`=1, the block SHALL immediately (asynchronously) force:
- `Serial_multout` = 0;
- `cnt` = 0;
- accumulator and operand registers = 0.
REQ-018 Reset asserted mid-operation SHALL abort the computation and leave `Serial_multout` at 0.
REQ-019 After `rst` deasserts, the first rising edge SHALL be a LOAD edge.
REQ-020 The previous result SHALL NOT be retained across a reset.

Verification
REQ-021 Max operands: `rst` high until 5 ns (clk period 10 ns, first rising edge at 10 ns), then `Serial_multin1`=0xFFFF and `Serial_multin2`=0xFFFF -> `Serial_multout`=0 through 169 ns; `Serial_multout`=0xFFFE0001 (4294836225) at the 170 ns edge.
REQ-022 Small operands: 3 x 5 -> `Serial_multout`=15 at the 17th edge after reset release; 0 before that edge.
REQ-023 Zero operand: 0x0000 x 0xABCD -> `Serial_multout` remains 0 and updates to 0 at edge 17; no spurious nonzero value at any edge.
REQ-024 Operand change mid-operation: load 0x1234 x 0x0010, change inputs to 0xFFFF/0xFFFF at edge 5 -> `Serial_multout`=0x00012340 at edge 17, then 0xFFFE0001 at edge 34.
REQ-025 Reset mid-operation: assert `rst` for 3 ns at edge 8 of 0xFFFF x 0x0002 -> `Serial_multout`=0 immediately; full product 0x0001FFFE is produced 17 edges after reset release.
REQ-026 Back-to-back results: hold 0x00FF x 0x0101 -> `Serial_multout`=0x0000FFFF at edges 17, 34, 51, stable between those edges.
